// File: rtl/ushift_pkg.sv
// Shared types for the universal shift register: operation encodings, sequencer states
// and a helper that picks out the repeatable (shift/rotate) operations.
package ushift_pkg;

  typedef enum logic [2:0] {
    OpHold = 3'b000,
    OpShr  = 3'b001,
    OpShl  = 3'b010,
    OpLoad = 3'b011,
    OpRor  = 3'b100,
    OpRol  = 3'b101,
    OpAsr  = 3'b110,
    OpClr  = 3'b111
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  // Only these ops honour the burst amount; hold/load/clear run exactly once.
  function automatic logic is_shift(input op_e op);
    return (op == OpShr) || (op == OpShl) || (op == OpRor) || (op == OpRol) || (op == OpAsr);
  endfunction

endpackage

// File: rtl/ushift_ctrl.sv
// Burst sequencer: decides per cycle whether an op is applied and which one,
// tracks the remaining repeat count and produces busy/done.
module ushift_ctrl
  import ushift_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             CLRb,
  input  op_e              op,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  output logic             apply,
  output op_e              cur_op,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  op_e              op_q, op_d;
  logic             done_q, done_d;

  always_ff @(posedge clk or negedge CLRb) begin
    if (!CLRb) begin
      state_q <= IDLE;
      rem_q   <= '0;
      op_q    <= OpHold;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    done_d  = 1'b0;
    apply   = 1'b0;
    cur_op  = op_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          cur_op = op;
          if (is_shift(op)) begin
            // amt = 0 leaves Q untouched but still completes the burst.
            if (amt != '0) begin
              apply = 1'b1;
              rem_d = amt - CNT_W'(1);
              if (amt != CNT_W'(1)) begin
                state_d = RUN;
              end else begin
                done_d = 1'b1;
              end
            end else begin
              done_d = 1'b1;
            end
          end else begin
            apply  = 1'b1;
            done_d = 1'b1;
          end
        end else if (en) begin
          apply  = 1'b1;
          cur_op = op;
        end
      end
      RUN: begin
        apply = 1'b1;
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = done_q;

endmodule

// File: rtl/ushift_reg_n.sv
// Parametrised universal shift register: WIDTH-bit datapath with load/shift/rotate/ASR/clear,
// sequenced by ushift_ctrl for single ops and repeated bursts.
module ushift_reg_n
  import ushift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             CLRb,
  input  logic [2:0]       op,
  input  logic             en,
  input  logic             start,
  input  logic [CNT_W-1:0] amt,
  input  logic [WIDTH-1:0] D,
  input  logic             LSD,
  input  logic             RSD,
  output logic [WIDTH-1:0] Q,
  output logic             SOL,
  output logic             SOR,
  output logic             busy,
  output logic             done
);

  logic             apply;
  op_e              cur_op;
  logic [WIDTH-1:0] q_q, q_d;

  ushift_ctrl #(
    .CNT_W(CNT_W)
  ) u_ctrl (
    .clk   (clk),
    .CLRb  (CLRb),
    .op    (op_e'(op)),
    .en    (en),
    .start (start),
    .amt   (amt),
    .apply (apply),
    .cur_op(cur_op),
    .busy  (busy),
    .done  (done)
  );

  always_ff @(posedge clk or negedge CLRb) begin
    if (!CLRb) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  // Serial inputs are taken live, so a burst of shifts streams LSD/RSD in.
  always_comb begin
    q_d = q_q;
    if (apply) begin
      case (cur_op)
        OpHold: q_d = q_q;
        OpShr:  q_d = {RSD, q_q[WIDTH-1:1]};
        OpShl:  q_d = {q_q[WIDTH-2:0], LSD};
        OpLoad: q_d = D;
        OpRor:  q_d = {q_q[0], q_q[WIDTH-1:1]};
        OpRol:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
        OpAsr:  q_d = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        OpClr:  q_d = '0;
        default: q_d = q_q;
      endcase
    end
  end

  assign Q   = q_q;
  assign SOL = q_q[WIDTH-1];
  assign SOR = q_q[0];

endmodule

// File: doc/ushift_reg_n.md
# ushift_reg_n

Parametrised universal shift register with a burst sequencer. Generalises the fixed-width cascaded shift register to any `WIDTH ≥ 2`. It adds rotate, arithmetic-shift and synchronous-clear operations, serial outputs, and a start/busy/done sequencer that repeats one operation a programmed number of times. It sits between parallel datapath logic and serial links: load/shift/rotate for serialisers, multi-bit shifts for ALU helpers.

## Interface
- `WIDTH`, default 8: register width; must be ≥ 2.
- `CNT_W`, default `$clog2(WIDTH+1)`: width of the burst amount.

Ports:
- `clk`  in  1  rising-edge clock.
- `CLRb`  in  1  reset: **asynchronous, active-low**. Clears all state.
- `op`  in  3  operation: 000 hold, 001 shift right (fill `RSD`), 010 shift left (fill `LSD`), 011 parallel load `D`, 100 rotate right, 101 rotate left, 110 arithmetic shift right, 111 synchronous clear.
- `en`  in  1  apply `op` once at this edge (idle only).
- `start`  in  1  begin a burst of `op` repeated `amt` times (idle only).
- `amt`  in  CNT_W  burst repeat count, sampled with `start`.
- `D`  in  WIDTH  parallel load data.
- `LSD`  in  1  serial input entering bit 0 on a left shift.
- `RSD`  in  1  serial input entering bit `WIDTH-1` on a right shift.
- `Q`  out  WIDTH  register contents.
- `SOL`  out  1  `Q[WIDTH-1]`, combinational.
- `SOR`  out  1  `Q[0]`, combinational.
- `busy`  out  1  burst in progress; further ops remain.
- `done`  out  1  one-cycle pulse after the final op of a burst.

## Operation
- **Right-direction ops** move data toward bit 0:
  - shift right: `Q <= {RSD, Q[W-1:1]}`.
  - rotate right: `Q <= {Q[0], Q[W-1:1]}`.
  - arithmetic shift right: `Q <= {Q[W-1], Q[W-1:1]}`.
- **Left-direction ops:**
  - shift left: `Q <= {Q[W-2:0], LSD}`.
  - rotate left: `Q <= {Q[W-2:0], Q[W-1]}`.
- **FSM states:** IDLE and RUN; remaining-count register `rem` (CNT_W bits).
- **IDLE, `start`=1 (priority over `en`):**
  - Latch `op`.
  - If `op` is a shift/rotate/ASR and `amt ≥ 1`: apply it once at this edge, set `rem = amt-1`, go to RUN if `rem > 0`.
  - If `amt = 0`: `Q` unchanged.
  - If `op` is hold, load or clear: execute once; `amt` is ignored.
  - `done` pulses the cycle after this edge whenever no RUN follows.
- **IDLE, `en`=1, `start`=0:** execute `op` once; no `done` pulse.
- **RUN:**
  - Each edge applies the latched op and decrements `rem`.
  - At the edge where `rem` goes 1→0: return to IDLE and set `done` = 1 for the next cycle.
  - `op`, `en`, `start` and `D` are ignored during RUN.
  - `LSD`/`RSD` are sampled live every cycle, so a burst shifts in a serial stream.
- **`busy`:** registered; equals `state == RUN`.
- **`amt` > WIDTH:** no clamping; the op repeats `amt` times.
- **Reset:** asserting `CLRb` at any time, including mid-burst, forces `Q = 0`, IDLE, `rem = 0`, `busy = 0`, `done = 0`.

## Timing
- **Reset values:** `Q = 0`, `SOL = 0`, `SOR = 0`, `busy = 0`, `done = 0`.
- **Single op latency:** `Q` updates at the sampling edge; 1 cycle.
- **Burst of N ≥ 1 ops** with `start` sampled at edge k:
  - Ops are applied at edges k … k+N-1.
  - `busy` is high for N-1 cycles.
  - `done` is high for the one cycle after edge k+N-1.
- **Back-to-back bursts:** a new `start` is accepted in the same cycle `done` is high. Zero-gap bursts are allowed.

## Structure
- **Package `ushift_pkg`:**
  - `op_e` enum, 3 bits, encodings as listed in Interface.
  - `state_e` enum {IDLE, RUN}.
  - Helper function `is_shift(op_e)`.
- **Sub-module `ushift_ctrl`:** FSM, `rem` counter, latched op, `busy`/`done`. Outputs per-cycle `apply` and `cur_op`.
- **Top `ushift_reg_n`:** holds the WIDTH-bit datapath mux and register, driven by `ushift_ctrl`.

## Test plan
All scenarios at WIDTH = 8 unless noted.
1. **Load and shift left:** `en`, op 011, D = 0xA5 → Q = 0xA5. Then `en`, op 010, LSD = 1 → Q = 0x4B, SOL = 0, SOR = 1.
2. **Burst rotate right:** Q = 0xA5, `start`, op 100, amt = 3 → Q sequence D2, 69, B4; `busy` high 2 cycles; `done` pulses once; final Q = 0xB4.
3. **Burst arithmetic shift right:** Q = 0x96, `start`, op 110, amt = 4 → Q = 0xF9, `done` pulse. Then `start` amt = 0 → `done` next cycle, Q stays 0xF9.
4. **Serial stream in:** Q = 0x00, `start`, op 001, amt = 8, RSD stream 1,0,1,1,0,0,1,0 → Q = 0x4D. `start` and `en` pulses during RUN have no effect.
5. **Reset mid-burst:** `CLRb` low during RUN (rem = 3) → Q = 0x00, `busy` = 0, `done` never pulses. After release, `en` load 0x3C → Q = 0x3C.
6. **WIDTH = 16 instance:** load 0x8001, `start` op 101 amt = 17 → Q = 0x0003. Then op 111 `en` → Q = 0x0000.
